// File: rtl/unflatten_stream_pkg.sv
// Shared CNN stage definitions: element width, pooled map geometry and the
// packed 2D map type used by both the flatten and unflatten stages.
package unflatten_stream_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int POOL_OFMAP_SIZE  = 2;
    localparam int POOL_PIXEL_COUNT = POOL_OFMAP_SIZE * POOL_OFMAP_SIZE;

    // One pooled feature map, row-major, element [0][0] first.
    typedef logic [0:POOL_OFMAP_SIZE-1][0:POOL_OFMAP_SIZE-1][DATA_WIDTH-1:0] pool_map_t;

    // Counter width able to hold 0..count-1, never narrower than one bit.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order position tracker for an N x N window: row/col plus linear
// index, advancing column-first, with an at_last flag on the final position.
// A restart request returns the position to the origin.
module raster_counter
    import unflatten_stream_pkg::*;
#(
    parameter int N = POOL_OFMAP_SIZE,
    localparam int RC_W  = cnt_width(N),
    localparam int IDX_W = cnt_width(N * N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             restart,
    output logic [RC_W-1:0]  row,
    output logic [RC_W-1:0]  col,
    output logic [IDX_W-1:0] idx,
    output logic             at_last
);

    localparam logic [RC_W-1:0]  COL_MAX = RC_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N * N - 1);

    logic [RC_W-1:0]  row_q, row_d;
    logic [RC_W-1:0]  col_q, col_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign row     = row_q;
    assign col     = col_q;
    assign idx     = idx_q;
    assign at_last = (idx_q == IDX_MAX);

    // Next position: origin on restart or wrap, otherwise step column-first.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        idx_d = idx_q;
        if (restart || (advance && at_last)) begin
            row_d = '0;
            col_d = '0;
            idx_d = '0;
        end else if (advance) begin
            idx_d = idx_q + 1'b1;
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/unflatten_stream.sv
// Rebuilds N x N pooled feature maps from a raster-ordered element stream.
// Two map banks ping-pong: one fills while the other is presented to the
// consumer. Framing errors on in_last are flagged sticky on frame_err.
module unflatten_stream
    import unflatten_stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:POOL_OFMAP_SIZE-1][0:POOL_OFMAP_SIZE-1][DATA_WIDTH-1:0] feature_out,
    output logic                  frame_err
);

    localparam int N     = POOL_OFMAP_SIZE;
    localparam int RC_W  = cnt_width(N);
    localparam int IDX_W = cnt_width(POOL_PIXEL_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POOL_PIXEL_COUNT - 1);

    logic [1:0] full_cnt_q, full_cnt_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic       frame_err_q, frame_err_d;

    logic [RC_W-1:0]  wr_row;
    logic [RC_W-1:0]  wr_col;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_at_last;

    logic accept;
    logic out_fire;
    logic complete;
    logic early_last;

    // in_ready depends only on the registered bank count, never on out_ready.
    assign in_ready   = (full_cnt_q != 2'd2);
    assign out_valid  = (full_cnt_q != 2'd0);
    assign frame_err  = frame_err_q;

    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign complete   = accept && wr_at_last;
    assign early_last = accept && in_last && (wr_idx != LAST_IDX);

    raster_counter #(
        .N (N)
    ) u_wr_pos (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .restart (accept && in_last),
        .row     (wr_row),
        .col     (wr_col),
        .idx     (wr_idx),
        .at_last (wr_at_last)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            pool_map_t bank_q, bank_d;

            // Capture the accepted element when this bank is the write target.
            always_comb begin
                bank_d = bank_q;
                if (accept && (int'(wr_bank_q) == gi)) begin
                    bank_d[wr_row][wr_col] = in_data;
                end
            end

            // Bank storage; reset clears the map to zeros.
            always_ff @(posedge clk) begin
                if (reset) begin
                    bank_q <= '0;
                end else begin
                    bank_q <= bank_d;
                end
            end
        end
    endgenerate

    assign feature_out = rd_bank_q ? g_bank[1].bank_q : g_bank[0].bank_q;

    // Bank pointers, completed-bank count and sticky framing error.
    // An early last leaves the pointers alone: the partial bank is simply
    // overwritten from the origin by the next map.
    always_comb begin
        wr_bank_d   = wr_bank_q ^ complete;
        rd_bank_d   = rd_bank_q ^ out_fire;
        full_cnt_d  = full_cnt_q + 2'(complete) - 2'(out_fire);
        frame_err_d = frame_err_q | early_last | (complete && !in_last);
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_cnt_q  <= 2'd0;
            frame_err_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_cnt_q  <= full_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_unflatten_stream.sv
// Bench for unflatten_stream: directed scenarios plus a randomized phase.
// A scoreboard process keeps an element-list reference model, queues every
// expected map and checks each presented map, in_ready, out_valid, frame_err.
module tb_unflatten_stream;
    import unflatten_stream_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data = '0;
    logic                  in_last = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    pool_map_t             feature_out;
    logic                  frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    pool_map_t             exp_q[$];
    logic [DATA_WIDTH-1:0] partial[$];
    bit                    exp_err = 1'b0;
    pool_map_t             sb_map;
    pool_map_t             new_map;
    bit                    rand_ready_en = 1'b0;

    unflatten_stream dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .feature_out (feature_out),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic pool_map_t mk_map(input int a, input int b, input int c, input int d);
        pool_map_t m;
        m[0][0] = DATA_WIDTH'(a);
        m[0][1] = DATA_WIDTH'(b);
        m[1][0] = DATA_WIDTH'(c);
        m[1][1] = DATA_WIDTH'(d);
        return m;
    endfunction

    // Scoreboard: compare the current cycle, then apply this cycle's handshakes
    // to the reference model (they take effect at the coming rising edge).
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            partial.delete();
            exp_err = 1'b0;
        end else begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            chk("frame_err", 64'(frame_err), 64'(exp_err));
            if (out_valid && out_ready && exp_q.size() != 0) begin
                sb_map = exp_q.pop_front();
                chk("feature_out", 64'(feature_out), 64'(sb_map));
                $display("map out: %h", feature_out);
            end
            if (in_valid && in_ready) begin
                partial.push_back(in_data);
                if (partial.size() == POOL_PIXEL_COUNT) begin
                    for (int i = 0; i < POOL_PIXEL_COUNT; i++)
                        new_map[i / POOL_OFMAP_SIZE][i % POOL_OFMAP_SIZE] = partial[i];
                    exp_q.push_back(new_map);
                    if (!in_last) exp_err = 1'b1;
                    partial.delete();
                end else if (in_last) begin
                    partial.delete();
                    exp_err = 1'b1;
                end
            end
        end
    end

    // Random consumer backpressure for the randomized phase.
    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [DATA_WIDTH-1:0] d, input bit last);
        int  waitc;
        bit  acc;
        waitc = 0;
        acc   = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waitc++;
        end while (!acc && waitc < 200);
        chk("send_accept", 64'(acc), 64'(1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        bit last;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_feature_out", 64'(feature_out), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_frame_err", 64'(frame_err), 64'(0));

        // Sequential fill with immediate consumption.
        out_ready = 1'b1;
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        chk("fill_out_valid", 64'(out_valid), 64'(1));
        chk("fill_map", 64'(feature_out), 64'(mk_map(1, 2, 3, 4)));
        idle(2);
        chk("fill_frame_err", 64'(frame_err), 64'(0));

        // Backpressure: two maps fill, input stalls, first map held.
        out_ready = 1'b0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        send(5, 0); send(6, 0); send(7, 0); send(8, 1);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        idle(2);
        chk("bp_hold_a", 64'(feature_out), 64'(mk_map(1, 2, 3, 4)));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_map_b", 64'(feature_out), 64'(mk_map(5, 6, 7, 8)));
        chk("bp_in_ready_high", 64'(in_ready), 64'(1));
        drain();

        // Back-to-back maps: one element per cycle, no stalls.
        out_ready = 1'b1;
        c0 = cyc;
        for (int m = 0; m < 4; m++)
            for (int i = 0; i < POOL_PIXEL_COUNT; i++)
                send(DATA_WIDTH'(16 + m * POOL_PIXEL_COUNT + i), i == POOL_PIXEL_COUNT - 1);
        c1 = cyc;
        chk("b2b_cycles", 64'(c1 - c0), 64'(4 * POOL_PIXEL_COUNT));
        drain();

        // Early last discards the partial map and flags an error.
        send(9, 0); send(10, 1);
        idle(2);
        chk("early_frame_err", 64'(frame_err), 64'(1));
        chk("early_no_valid", 64'(out_valid), 64'(0));
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        chk("early_next_map", 64'(feature_out), 64'(mk_map(1, 2, 3, 4)));
        drain();

        // Missing last: map still completes, error flagged.
        do_reset();
        chk("ml_err_cleared", 64'(frame_err), 64'(0));
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        chk("ml_map", 64'(feature_out), 64'(mk_map(1, 2, 3, 4)));
        chk("ml_frame_err", 64'(frame_err), 64'(1));
        drain();

        // Reset mid-frame discards the partial map.
        send(1, 0); send(2, 0);
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_frame_err", 64'(frame_err), 64'(0));
        send(5, 0); send(6, 0); send(7, 0); send(8, 1);
        chk("rst_map", 64'(feature_out), 64'(mk_map(5, 6, 7, 8)));
        idle(1);
        chk("rst_frame_err_after", 64'(frame_err), 64'(0));
        drain();

        // Randomized traffic with occasional framing faults.
        do_reset();
        rand_ready_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            last = ((k % POOL_PIXEL_COUNT) == POOL_PIXEL_COUNT - 1);
            if ($urandom_range(0, 19) == 0) last = !last;
            send(DATA_WIDTH'($urandom), last);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        rand_ready_en = 1'b0;
        @(posedge clk);
        #2;
        drain();
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/unflatten_stream.md
# unflatten_stream

Streaming reshape stage: accepts a raster-ordered pixel stream (one flattened pooled-feature element per handshake) and rebuilds the POOL_OFMAP_SIZE×POOL_OFMAP_SIZE 2D feature map, presenting complete maps on a valid/ready output. It is the inverse of the flatten stage. It sits between a serial source and any 2D consumer, such as the next conv/pool window loader or a debug readback path. It is double-buffered, so one map can be filled while the previous map waits for the consumer.

## Interface
- DATA_WIDTH, 8, element width in bits
- POOL_OFMAP_SIZE, 2, map side length N (must be ≥ 2)
- POOL_PIXEL_COUNT, POOL_OFMAP_SIZE*POOL_OFMAP_SIZE, elements per map (derived; not overridden)

Ports:
- clk  input  1  clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input element present
- in_ready  output  1  block can accept an element
- in_data  input  DATA_WIDTH  element value, row-major order
- in_last  input  1  marks the final element of a map
- out_valid  output  1  complete map available
- out_ready  input  1  consumer takes the map
- feature_out  output  [DATA_WIDTH-1:0] [0:N-1][0:N-1]  map being presented
- frame_err  output  1  sticky flag: an in_last framing violation occurred

## Operation
- The block holds two banks of N×N registers.
  - wr_bank/rd_bank: 1-bit pointers.
  - full_cnt: number of completed banks, 0..2.
  - wr_idx: 0..POOL_PIXEL_COUNT-1.
- Input handshake: an element is accepted when in_valid && in_ready. in_ready = (full_cnt != 2).
- Accepted element index i is written to bank[wr_bank][i/N][i%N]. The row/col counters increment column-first and wrap the column at N-1.
- Bank completion occurs when an element is accepted at wr_idx == POOL_PIXEL_COUNT-1:
  - wr_idx → 0
  - wr_bank toggles
  - full_cnt += 1
- Framing rules:
  - in_last on the final element: normal completion.
  - in_last missing on the final element: the bank still completes, and frame_err is set.
  - in_last on an element with wr_idx < POOL_PIXEL_COUNT-1 (early last): the element is written, then the partial bank is discarded. wr_idx → 0, wr_bank is unchanged, full_cnt is unchanged, and frame_err is set.
- Output: out_valid = (full_cnt != 0). feature_out = bank[rd_bank].
  - On out_valid && out_ready, rd_bank toggles and full_cnt -= 1.
- Simultaneous bank completion and output handshake: full_cnt is unchanged and both pointers toggle.
- feature_out is a registered bank. Its contents are stable while out_valid && !out_ready.
- The write bank is never the bank being presented unless full_cnt == 0.
- frame_err is cleared only by reset.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - frame_err = 0
  - feature_out = all zeros (banks cleared)
  - pointers, wr_idx, full_cnt = 0
- Reset mid-frame discards all partial and full banks in the same cycle.
- Latency: out_valid rises the cycle after the final element is accepted.
- Throughput: one element per cycle sustained while out_ready is held high. No bubbles occur between maps.
- in_ready falls the cycle after the second bank completes with no output taken. It rises the cycle after an output handshake.
- There is no combinational path from out_ready to in_ready. in_ready depends only on registered full_cnt.
- frame_err asserts the cycle after the offending handshake.

## Structure
- DATA_WIDTH, POOL_OFMAP_SIZE and POOL_PIXEL_COUNT come from the shared cnn_defs.svh package, alongside the existing flatten stage's constants.
- Add a packed typedef for the N×N map type (pool_map_t) to the same package so that flatten and unflatten_stream share it.
- One sub-module: raster_counter, which provides row/col/linear index with wrap and an at_last flag. The parameter is N. It is reusable by other window loaders.
- The bank registers, pointers and full_cnt logic stay in the top module.

## Test plan
- Sequential fill: send 1,2,3,4 with in_last on 4 and out_ready=1 → out_valid is high one cycle after the 4th accept, with feature_out = [[1,2],[3,4]]; frame_err = 0.
- Backpressure: hold out_ready=0 and send maps A=1..4 and B=5..8 → in_ready drops after B completes, and feature_out = A is held. Raise out_ready for one cycle → feature_out = [[5,6],[7,8]] and in_ready returns to 1.
- Back-to-back streaming: send 4 maps continuously with out_ready=1 → in_ready is never deasserted, and the 4 output maps are in order and match the flatten-stage inverse.
- Early last: send 9, then 10 with in_last → frame_err=1 and no out_valid. Then send 1..4 with last → output [[1,2],[3,4]].
- Missing last: send 1..4 with no in_last → map [[1,2],[3,4]] is still output, and frame_err=1.
- Reset mid-frame: accept 2 elements, assert reset for one cycle, then send 5..8 with last → the output is exactly [[5,6],[7,8]], out_valid was 0 through reset, and frame_err = 0.
